// File: rtl/keypad_pkg.sv
// Shared types, column/row constants and the key-code map for the 4x4 keypad bus.
// The key map matches the scanner decode so a scanner checker can reuse it.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StGap
  } state_e;

  localparam logic [3:0] COL0 = 4'b1000;
  localparam logic [3:0] COL1 = 4'b0100;
  localparam logic [3:0] COL2 = 4'b0010;
  localparam logic [3:0] COL3 = 4'b0001;

  localparam logic [3:0] ROW0 = 4'b1000;
  localparam logic [3:0] ROW1 = 4'b0100;
  localparam logic [3:0] ROW2 = 4'b0010;
  localparam logic [3:0] ROW3 = 4'b0001;

  // Returns {col, row} for a hex key code.
  function automatic logic [7:0] keymap(input logic [KEY_W-1:0] code);
    logic [7:0] m;
    m = '0;
    unique case (code)
      4'h1: m = {COL0, ROW0};
      4'h4: m = {COL0, ROW1};
      4'h7: m = {COL0, ROW2};
      4'hE: m = {COL0, ROW3};
      4'h2: m = {COL1, ROW0};
      4'h5: m = {COL1, ROW1};
      4'h8: m = {COL1, ROW2};
      4'h0: m = {COL1, ROW3};
      4'h3: m = {COL2, ROW0};
      4'h6: m = {COL2, ROW1};
      4'h9: m = {COL2, ROW2};
      4'hF: m = {COL2, ROW3};
      4'hA: m = {COL3, ROW0};
      4'hB: m = {COL3, ROW1};
      4'hC: m = {COL3, ROW2};
      4'hD: m = {COL3, ROW3};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small key-code FIFO with wrapping pointers and one extra bit for full/empty.
// Read data is the combinational head entry.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [KEY_W-1:0] wdata_i,
  output logic [KEY_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [KEY_W-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A simultaneous pop frees the head slot, so a push may land even when full.
  assign push_en = push_i & (~full_o | pop_i);
  assign pop_en  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_en) wptr_d = wptr_q + 1'b1;
    if (pop_en)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk1) begin
    if (push_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad-side responder for the scanner: presses queued keys for PRESS_CYCLES,
// then releases them for GAP_CYCLES, driving rows from the scanner's column drives.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned PRESS_CYCLES = 64,
  parameter int unsigned GAP_CYCLES   = 64,
  parameter int unsigned CNTW         = 16,
  parameter int unsigned DEPTH        = 2
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             key_ready,
  input  logic [3:0]       cols,
  output logic [3:0]       rows,
  output logic             busy,
  output logic             pressed,
  output logic             done
);

  localparam logic [CNTW-1:0] PressLoad = CNTW'(PRESS_CYCLES - 1);
  localparam logic [CNTW-1:0] GapLoad   = CNTW'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [3:0]       tcol_q, tcol_d;
  logic [3:0]       trow_q, trow_d;
  logic             avail_q;
  logic             fifo_full, fifo_empty, push, pop, start;
  logic [KEY_W-1:0] fifo_rdata;

  key_fifo #(
    .DEPTH(DEPTH)
  ) u_key_fifo (
    .clk1    (clk1),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (key_code),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign key_ready = ~fifo_full;
  assign push      = key_valid & key_ready;

  // IDLE acts on a registered head-valid flag, so a fresh key reaches PRESS
  // two edges after its push; a key already queued during GAP is not delayed.
  assign start = (state_q == StIdle) & avail_q & ~fifo_empty;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tcol_q  <= '0;
      trow_q  <= '0;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcol_q  <= tcol_d;
      trow_q  <= trow_d;
      avail_q <= ~fifo_empty;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcol_d  = tcol_q;
    trow_d  = trow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          {tcol_d, trow_d} = keymap(fifo_rdata);
          cnt_d            = PressLoad;
          state_d          = StPress;
        end
      end
      StPress: begin
        if (cnt_q == '0) begin
          cnt_d   = GapLoad;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop     = start;
    pressed = (state_q == StPress);
    done    = (state_q == StGap) && (cnt_q == '0);
    busy    = ~fifo_empty | (state_q != StIdle);
    // Bit-test models a physical switch: any driven column containing the key closes it.
    rows    = (pressed && ((cols & tcol_q) != 4'b0000)) ? trow_q : 4'b0000;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomised bench for keypad_emulator against a timeline model of queued key presses.
module tb_keypad_emulator;

  localparam int P = 8;
  localparam int G = 4;
  localparam int D = 2;

  logic       clk1 = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       busy;
  logic       pressed;
  logic       done;

  keypad_emulator #(
    .PRESS_CYCLES(P),
    .GAP_CYCLES  (G),
    .CNTW        (16),
    .DEPTH       (D)
  ) dut (
    .clk1      (clk1),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .cols      (cols),
    .rows      (rows),
    .busy      (busy),
    .pressed   (pressed),
    .done      (done)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_errors = 0;

  // Keypad layout: layout[column][row] holds the hex code of that switch.
  int layout [4][4] = '{'{1, 4, 7, 14}, '{2, 5, 8, 0}, '{3, 6, 9, 15}, '{10, 11, 12, 13}};

  // Model: each accepted key has a push edge and a press-start edge.
  int         push_a[$];
  int         start_a[$];
  logic [3:0] code_a[$];
  int         last_start;
  int         cyc;
  int         done_cyc[$];
  logic       obs_pressed, obs_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] key_col(input logic [3:0] code);
    logic [3:0] r;
    r = 4'b0000;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        if (layout[c][w] == int'(code)) r = 4'b1000 >> c;
    return r;
  endfunction

  function automatic logic [3:0] key_row(input logic [3:0] code);
    logic [3:0] r;
    r = 4'b0000;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        if (layout[c][w] == int'(code)) r = 4'b1000 >> w;
    return r;
  endfunction

  task automatic model_clear();
    push_a.delete();
    start_a.delete();
    code_a.delete();
    last_start = -1000;
    cyc        = 0;
  endtask

  // Called at a negedge: checks cycle cyc, offers a key for the next edge, advances one cycle.
  task automatic step(input logic v, input logic [3:0] code, input logic [3:0] col);
    logic [3:0] exp_rows;
    logic       exp_p, exp_busy, exp_done;
    int         occ, s;
    cols = col;
    #1;
    exp_rows = 4'b0000;
    exp_p    = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    occ      = 0;
    for (int i = 0; i < push_a.size(); i++) begin
      s = start_a[i];
      if (push_a[i] <= cyc && s > cyc) occ++;
      if (push_a[i] <= cyc && s + P + G > cyc) exp_busy = 1'b1;
      if (s <= cyc && cyc < s + P) begin
        exp_p = 1'b1;
        if ((col & key_col(code_a[i])) != 4'b0000) exp_rows = key_row(code_a[i]);
      end
      if (cyc == s + P + G - 1) exp_done = 1'b1;
    end
    check_eq("rows", 32'(rows), 32'(exp_rows));
    check_eq("pressed", 32'(pressed), 32'(exp_p));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("done", 32'(done), 32'(exp_done));
    check_eq("key_ready", 32'(key_ready), 32'(occ < D));
    obs_pressed = pressed;
    obs_done    = done;
    if (done) done_cyc.push_back(cyc);
    key_valid = v;
    key_code  = code;
    if (v && occ < D) begin
      s = (cyc + 3 > last_start + P + G + 1) ? cyc + 3 : last_start + P + G + 1;
      push_a.push_back(cyc + 1);
      start_a.push_back(s);
      code_a.push_back(code);
      last_start = s;
    end
    @(posedge clk1);
    cyc++;
    @(negedge clk1);
  endtask

  logic [3:0] pat [4] = '{4'b0100, 4'b1000, 4'b1100, 4'b0000};
  int         npress, ndone, tries, nkeys;

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    cols      = 4'b0000;
    model_clear();
    repeat (3) @(negedge clk1);

    // Under reset: outputs idle whatever the columns do.
    for (int i = 0; i < 16; i++) begin
      cols = 4'(i);
      #1;
      check_eq("rst_rows", 32'(rows), 32'h0);
    end
    check_eq("rst_ready", 32'(key_ready), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_pressed", 32'(pressed), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    @(negedge clk1);
    reset = 1'b1;
    model_clear();

    for (int i = 0; i < 16; i++) step(1'b0, 4'(i), 4'(i));

    // Key 5 with column patterns during the press.
    step(1'b1, 4'h5, 4'b0000);
    npress = 0;
    ndone  = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'h0, pat[i % 4]);
      if (obs_pressed) npress++;
      if (obs_done) ndone++;
    end
    check_eq("key5_press_len", 32'(npress), 32'(P));
    check_eq("key5_done_cnt", 32'(ndone), 32'h1);

    // Three back-to-back keys into a depth-2 FIFO.
    done_cyc.delete();
    nkeys = push_a.size();
    step(1'b1, 4'h3, 4'($urandom));
    step(1'b1, 4'h6, 4'($urandom));
    tries = 0;
    while (push_a.size() < nkeys + 3 && tries < 20) begin
      step(1'b1, 4'h9, 4'($urandom));
      tries++;
    end
    check_eq("third_key_accepted", 32'(push_a.size() - nkeys), 32'h3);
    for (int i = 0; i < 3 * (P + G + 1) + 8; i++) step(1'b0, 4'($urandom), 4'($urandom));
    check_eq("b2b_done_cnt", 32'(done_cyc.size()), 32'h3);
    if (done_cyc.size() == 3) begin
      check_eq("b2b_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'(P + G + 1));
      check_eq("b2b_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'(P + G + 1));
    end

    // Reset in the middle of pressing key E.
    step(1'b1, 4'hE, 4'b1000);
    tries = 0;
    obs_pressed = 1'b0;
    while (!obs_pressed && tries < 10) begin
      step(1'b0, 4'h0, 4'b1000);
      tries++;
    end
    check_eq("e_press_reached", 32'(obs_pressed), 32'h1);
    step(1'b0, 4'h0, 4'b1000);
    cols  = 4'b1000;
    reset = 1'b0;
    #1;
    check_eq("midrst_rows", 32'(rows), 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'h0);
    check_eq("midrst_pressed", 32'(pressed), 32'h0);
    check_eq("midrst_ready", 32'(key_ready), 32'h1);
    check_eq("midrst_done", 32'(done), 32'h0);
    @(posedge clk1);
    @(negedge clk1);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 20; i++) step(1'b0, 4'($urandom), 4'($urandom));

    // Random traffic.
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Self-test responder for the 4x4 keypad bus. It plays the keypad's side of the scan protocol: it watches the column drives from the key scanner and drives the row lines as if one key were pressed. Key codes are queued through a valid/ready interface, and each key is pressed for a programmed time, then released for a programmed gap. It sits between the on-chip BIST sequencer and the row inputs of the scanner, muxed in ahead of the row pads.

Parameters:
PRESS_CYCLES, 64, clocks a key is held down; must exceed 4 scanner slowen periods so every column is visited at least once.
GAP_CYCLES, 64, clocks of all-rows-low after release, so the scanner clears its lastrow record.
CNTW, 16, width of the press/gap down-counter; PRESS_CYCLES and GAP_CYCLES must each be at most 2^CNTW-1.
DEPTH, 2, key FIFO depth (power of 2, at least 2).

Ports:
clk1  in  1  system clock, the only clock
reset  in  1  asynchronous, active-low reset
key_valid  in  1  a key code is offered
key_code  in  4  hex value of the key to press
key_ready  out  1  FIFO not full; a transfer happens on a clk1 edge where key_valid & key_ready
cols  in  4  column drives from the scanner (one-hot, 1000 = column 0)
rows  out  4  emulated row lines, active-high
busy  out  1  FIFO non-empty or FSM not IDLE
pressed  out  1  FSM in PRESS
done  out  1  one-cycle pulse at the end of each key's gap

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE, FIFO empties, counter is 0.
  - Output values under reset: rows=0000, key_ready=1, busy=0, pressed=0, done=0.
  - rows goes to 0 immediately, even in the middle of a press.
- Key map (code -> column bit, row bit), matching the scanner decode:
  - column 0 (cols 1000): 1->1000, 4->0100, 7->0010, E->0001
  - column 1 (cols 0100): 2, 5, 8, 0
  - column 2 (cols 0010): 3, 6, 9, F
  - column 3 (cols 0001): A, B, C, D
- FIFO:
  - Push on key_valid & key_ready.
  - Pop when the FSM leaves IDLE.
  - A push and a pop in the same cycle are both allowed when the FIFO is full; key_ready is still low that cycle (key_ready = !full, registered-state based).
  - Pointers are DEPTH-wrapping, with one extra bit for full/empty.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: if the FIFO is non-empty, pop the head, latch tcol/trow from the key map, load the counter with PRESS_CYCLES-1, and go to PRESS. Latency from push into an empty FIFO to PRESS is 2 clk1 edges.
  - PRESS: pressed=1. The counter decrements each cycle. At counter==0, load GAP_CYCLES-1 and go to GAP.
  - GAP: rows=0. The counter decrements each cycle. At counter==0, pulse done and go to IDLE. A queued key therefore starts on the next edge, with no extra idle cycle beyond the one IDLE cycle.
- rows is combinational from cols: rows = (state==PRESS && (cols & tcol)!=0) ? trow : 0000.
  - The bit-test models a physical switch. If several columns are high, the row is still driven when the target column is among them.
  - If cols=0000, rows=0000.
- rows must never be driven outside PRESS, including on the cycle of the transition into PRESS.
- key_code is sampled only on a push. Later changes to key_code do not affect queued or active keys.
- busy = !empty | (state!=IDLE).
- done is not asserted during reset.

Decomposition:
- Shared package keypad_pkg:
  - state enum (IDLE, PRESS, GAP)
  - column one-hot constants COL0..COL3 = 1000..0001
  - function keymap(code) returning {col[3:0], row[3:0]}; the same table also serves a future scanner checker.
- One sub-module: key_fifo (parameter DEPTH, width 4, clk1, reset, push/pop/full/empty). The FSM, counter and row logic stay in keypad_emulator.

Test Plan:
- Reset then idle: rows=0000, key_ready=1, busy=0. Sweep cols through all 16 values; rows stays 0000.
- Push 5 with PRESS_CYCLES=8, GAP_CYCLES=4:
  - pressed rises 2 edges after the push and holds 8 cycles.
  - While pressed: cols=0100 -> rows=0100; cols=1000 -> rows=0000; cols=1100 -> rows=0100.
  - Then 4 gap cycles, then done pulses once.
- Loopback with the scanner (TIMEBITS=2), pushing keys 1, F, 0, D: the scanner's currentDigit shows each value in order, and lastDigit equals the previous key.
- Back-to-back and full:
  - Push 3 keys with DEPTH=2: key_ready drops after the 2nd push (FSM still IDLE).
  - The 3rd key is held until the pop.
  - done pulses 3 times, exactly PRESS+GAP+1 cycles apart.
- Reset mid-PRESS of key E (cols=1000): rows goes to 0000 asynchronously. After release, FIFO is empty, busy=0, and no done pulse.
